// File: rtl/coin_acceptor_frontend.sv
// Purpose : synchronise and debounce two coin-slot sensors, then turn clean rising
//           edges into one-cycle coin_1 / coin_2 pulses, or a reject pulse for refused insertions.
// Latency : SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges from the first edge that samples a sensor high.
// Backpressure: none; the controller consumes pulses directly, and busy flags the post-coin lockout.
// Ports   : clk, reset (sync, active-low), sensor_1/sensor_2 (raw async), enable,
//           coin_1/coin_2/reject (one-cycle pulses), busy (lockout active).
module coin_acceptor_frontend #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_1,
  input  logic sensor_2,
  input  logic enable,
  output logic coin_1,
  output logic coin_2,
  output logic reject,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  // Channel 0 = sensor_1, channel 1 = sensor_2.
  logic [1:0]             w_sensor;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [CW-1:0]          r_cnt  [2];
  logic [1:0]             w_s;
  logic [1:0]             r_deb;
  logic [1:0]             r_deb_q;
  logic [1:0]             w_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LW-1:0]          r_lcnt;
  logic [LW-1:0]          w_lcnt_nxt;
  logic                   w_coin_1_nxt;
  logic                   w_coin_2_nxt;
  logic                   w_reject_nxt;
  logic                   w_busy_nxt;
  logic                   r_coin_1;
  logic                   r_coin_2;
  logic                   r_reject;
  logic                   r_busy;

  assign w_sensor = {sensor_2, sensor_1};
  assign w_s      = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};

  // Debounced levels (and their delayed copies) come out of reset high, so a
  // sensor already high at reset release must first debounce low before a
  // rising edge can ever be seen on that channel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        r_sync[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_deb   <= 2'b11;
      r_deb_q <= 2'b11;
    end else begin
      r_deb_q <= r_deb;
      for (int c = 0; c < 2; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_sensor[c]};
        if (w_s[c] == r_deb[c]) begin
          // Any agreeing cycle restarts the count: glitches shorter than
          // DEBOUNCE_CYCLES never reach the debounced level.
          r_cnt[c] <= '0;
        end else if (r_cnt[c] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[c] <= w_s[c];
          r_cnt[c] <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  // Only rising debounced edges matter; a coin leaving the slot is ignored.
  assign w_rise = r_deb & ~r_deb_q;

  always_comb begin
    w_state_nxt  = r_state;
    w_lcnt_nxt   = r_lcnt;
    w_coin_1_nxt = 1'b0;
    w_coin_2_nxt = 1'b0;
    w_reject_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_rise) begin
          if (!enable || (&w_rise)) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_coin_1_nxt = w_rise[0];
            w_coin_2_nxt = w_rise[1];
            w_state_nxt  = ST_LOCKOUT;
            w_lcnt_nxt   = LW'(LOCKOUT_CYCLES - 1);
          end
        end
      end
      ST_LOCKOUT: begin
        // Insertions during lockout are refused but do not extend it.
        w_reject_nxt = |w_rise;
        if (r_lcnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_lcnt_nxt = r_lcnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // busy is registered alongside the state so it rises with the coin pulse.
    w_busy_nxt = (w_state_nxt == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_lcnt   <= '0;
      r_coin_1 <= 1'b0;
      r_coin_2 <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lcnt   <= w_lcnt_nxt;
      r_coin_1 <= w_coin_1_nxt;
      r_coin_2 <= w_coin_2_nxt;
      r_reject <= w_reject_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign coin_1 = r_coin_1;
  assign coin_2 = r_coin_2;
  assign reject = r_reject;
  assign busy   = r_busy;

endmodule
